// File: rtl/sys_timectl.sv
// System timing controller: CPU clock divider with clock-enable, power-on reset
// sequencer and a small memory-mapped real-time clock with interrupt.
module sys_timectl #(
  parameter int OSC_CLOCK = 12000000,
  parameter int CPU_CLOCK = 3000000,
  parameter int RTC_CLOCK = 50,
  parameter int RES_DELAY = 4
) (
  input  logic       clk_in,
  input  logic       b_reset,
  output logic       sys_clk,
  output logic       cpu_ce,
  output logic       sys_res,
  input  logic       cs,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] di,
  output logic [7:0] rdata,  // read data bus; "do" is a SystemVerilog keyword
  output logic       irq
);
  localparam int CLK_DIV = OSC_CLOCK / CPU_CLOCK / 2;
  localparam int RTC_DIV = OSC_CLOCK / RTC_CLOCK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PRE_W   = $clog2(RTC_DIV);
  localparam int SUB_W   = (RTC_CLOCK > 1) ? $clog2(RTC_CLOCK) : 1;
  localparam int RES_W   = $clog2(RES_DELAY + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RTC_DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(RTC_CLOCK - 1);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(RES_DELAY - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [RES_W-1:0] res_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [SUB_W-1:0] sub_cnt;
  logic             ie;
  logic             run;
  logic             tf;
  logic [7:0]       ticks;
  logic [7:0]       secs;
  logic             ce_next;
  logic             wr;
  logic             tick;
  logic             sub_wrap;

  // cpu_ce is registered alongside the rising sys_clk so both change on the same edge
  assign ce_next  = (div_cnt == DIV_LAST) && !sys_clk;
  assign wr       = cpu_ce && cs && !rw && !sys_res;
  assign tick     = run && (pre_cnt == PRE_LAST);
  assign sub_wrap = (sub_cnt == SUB_LAST);

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      div_cnt <= '0;
      sys_clk <= 1'b0;
      cpu_ce  <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sys_clk <= ~sys_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      cpu_ce <= ce_next;
    end
  end

  // sys_res drops on the edge that raises the final counted cpu_ce
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      res_cnt <= '0;
      sys_res <= 1'b1;
    end else if (sys_res && ce_next) begin
      if (res_cnt == RES_LAST) begin
        sys_res <= 1'b0;
      end else begin
        res_cnt <= res_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      ie      <= 1'b0;
      run     <= 1'b0;
      tf      <= 1'b0;
      ticks   <= 8'h00;
      secs    <= 8'h00;
      pre_cnt <= '0;
      sub_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      irq <= tf && ie;
      if (wr && addr == 2'd0) begin
        ie  <= di[0];
        run <= di[1];
      end
      // a tick always wins over a CPU clear, a CPU load always wins over a tick
      if (tick) begin
        tf <= 1'b1;
      end else if (wr && addr == 2'd1 && di[0]) begin
        tf <= 1'b0;
      end
      if (wr && addr == 2'd2) begin
        ticks <= di;
      end else if (tick) begin
        ticks <= ticks + 8'd1;
      end
      if (wr && addr == 2'd3) begin
        secs <= di;
      end else if (tick && sub_wrap) begin
        secs <= secs + 8'd1;
      end
      if (!run) begin
        pre_cnt <= '0;
        sub_cnt <= '0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (tick) begin
          sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata = 8'hFF;
    if (cs && rw) begin
      case (addr)
        2'd0:    rdata = {6'b0, run, ie};
        2'd1:    rdata = {7'b0, tf};
        2'd2:    rdata = ticks;
        default: rdata = secs;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_timectl.sv
// Testbench for sys_timectl: randomized CPU traffic checked against a
// cycle-count based reference model of the clock, reset and RTC rules.
module tb_sys_timectl;
  localparam int OSC_CLOCK = 48;
  localparam int CPU_CLOCK = 12;
  localparam int RTC_CLOCK = 4;
  localparam int RES_DELAY = 4;
  localparam int CLK_DIV   = OSC_CLOCK / CPU_CLOCK / 2;
  localparam int RTC_DIV   = OSC_CLOCK / RTC_CLOCK;

  logic       clk_in = 1'b0;
  logic       b_reset = 1'b0;
  logic       cs = 1'b0;
  logic       rw = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] di = 8'h00;
  logic       sys_clk, cpu_ce, sys_res, irq;
  logic [7:0] rdata;

  int n_chk = 0;
  int n_fail = 0;

  sys_timectl #(
    .OSC_CLOCK(OSC_CLOCK),
    .CPU_CLOCK(CPU_CLOCK),
    .RTC_CLOCK(RTC_CLOCK),
    .RES_DELAY(RES_DELAY)
  ) dut (
    .clk_in (clk_in),
    .b_reset(b_reset),
    .sys_clk(sys_clk),
    .cpu_ce (cpu_ce),
    .sys_res(sys_res),
    .cs     (cs),
    .rw     (rw),
    .addr   (addr),
    .di     (di),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: k counts clk_in edges since reset release
  int         k, ce_seen, run_cyc, m_sub, nk;
  logic       m_ce, m_sres, m_sclk, m_irq, m_ie, m_run, m_tf;
  logic [7:0] m_ticks, m_secs;
  logic       m_wr, m_tick, nce;

  always_comb begin
    m_wr   = m_ce && cs && !rw && !m_sres;
    m_tick = m_run && ((run_cyc % RTC_DIV) == RTC_DIV - 1);
    nk     = k + 1;
    nce    = (nk % (2 * CLK_DIV)) == CLK_DIV;
  end

  always @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      k <= 0; ce_seen <= 0; run_cyc <= 0; m_sub <= 0;
      m_ce <= 1'b0; m_sres <= 1'b1; m_sclk <= 1'b0; m_irq <= 1'b0;
      m_ie <= 1'b0; m_run <= 1'b0; m_tf <= 1'b0;
      m_ticks <= 8'h00; m_secs <= 8'h00;
    end else begin
      k       <= nk;
      m_sclk  <= ((nk / CLK_DIV) % 2) == 1;
      m_ce    <= nce;
      ce_seen <= ce_seen + (nce ? 1 : 0);
      if (ce_seen + (nce ? 1 : 0) >= RES_DELAY) m_sres <= 1'b0;
      m_irq <= m_tf && m_ie;
      if (m_wr && addr == 2'd0) begin
        m_ie  <= di[0];
        m_run <= di[1];
      end
      if (m_tick) m_tf <= 1'b1;
      else if (m_wr && addr == 2'd1 && di[0]) m_tf <= 1'b0;
      if (m_wr && addr == 2'd2) m_ticks <= di;
      else if (m_tick) m_ticks <= m_ticks + 8'd1;
      if (m_wr && addr == 2'd3) m_secs <= di;
      else if (m_tick && m_sub == RTC_CLOCK - 1) m_secs <= m_secs + 8'd1;
      m_sub   <= !m_run ? 0 : (m_tick ? (m_sub + 1) % RTC_CLOCK : m_sub);
      run_cyc <= m_run ? run_cyc + 1 : 0;
    end
  end

  function automatic logic [7:0] exp_rd(input logic c, input logic r, input logic [1:0] a);
    if (!(c && r)) return 8'hFF;
    case (a)
      2'd0:    return {6'b0, m_run, m_ie};
      2'd1:    return {7'b0, m_tf};
      2'd2:    return m_ticks;
      default: return m_secs;
    endcase
  endfunction

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk_in);
    for (int n = 0; n < 16 && !m_ce; n++) @(negedge clk_in);
    cs = 1'b1; rw = 1'b0; addr = a; di = d;
    @(negedge clk_in);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic test_reset();
    b_reset = 1'b0; cs = 1'b1; rw = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    n_chk++;
    if ({sys_clk, cpu_ce, sys_res, irq} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected 0010", {sys_clk, cpu_ce, sys_res, irq});
    end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      n_chk++;
      if (rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected 00", a, rdata);
      end
    end
    cs = 1'b0; #1;
    n_chk++;
    if (rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_cs0_read: got %h expected ff", rdata);
    end
    @(negedge clk_in);
    b_reset = 1'b1;
  endtask

  task automatic test_reset_seq();
    int  ces = 0;
    bit  tried = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (m_ce) ces++;
      if (m_ce && m_sres && !tried) begin
        cs = 1'b1; rw = 1'b0; addr = 2'd0; di = 8'h03; tried = 1;
      end else begin
        cs = 1'b1; rw = 1'b1; addr = 2'd0;
      end
      #1;
      n_chk++;
      if ({sys_clk, cpu_ce, sys_res, irq} !== {m_sclk, m_ce, m_sres, m_irq}) begin
        n_fail++;
        $display("FAIL seq_outs cyc%0d: got %b expected %b", i, {sys_clk, cpu_ce, sys_res, irq},
                 {m_sclk, m_ce, m_sres, m_irq});
      end
      if (rw) begin
        n_chk++;
        if (rdata !== 8'h00) begin
          n_fail++;
          $display("FAIL seq_blocked_write cyc%0d: got %h expected 00", i, rdata);
        end
      end
      if (m_ce && (ces == RES_DELAY - 1 || ces == RES_DELAY)) begin
        n_chk++;
        if (sys_res !== (ces == RES_DELAY - 1)) begin
          n_fail++;
          $display("FAIL seq_res_at_ce%0d: got %b expected %b", ces, sys_res, ces == RES_DELAY - 1);
        end
      end
    end
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic test_rtc_run();
    bit done = 0;
    cpu_wr(2'd0, 8'h03);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_in);
      cs = 1'b1; rw = 1'b1; addr = 2'($urandom);
      #1;
      n_chk++;
      if ({sys_clk, cpu_ce, sys_res, irq, rdata} !== {m_sclk, m_ce, m_sres, m_irq, exp_rd(cs, rw, addr)}) begin
        n_fail++;
        $display("FAIL run_state cyc%0d: got %b/%h expected %b/%h", i, {sys_clk, cpu_ce, sys_res, irq},
                 rdata, {m_sclk, m_ce, m_sres, m_irq}, exp_rd(cs, rw, addr));
      end
      if (m_ticks == 8'h04) done = 1;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL run_timeout: got %h ticks expected 04", m_ticks);
    end
    addr = 2'd2; #1;
    n_chk++;
    if (rdata !== 8'h04) begin
      n_fail++;
      $display("FAIL run_ticks4: got %h expected 04", rdata);
    end
    addr = 2'd3; #1;
    n_chk++;
    if (rdata !== 8'h01) begin
      n_fail++;
      $display("FAIL run_secs1: got %h expected 01", rdata);
    end
    cs = 1'b0;
  endtask

  task automatic test_tf_clear();
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk_in);
      if (m_ce && m_tick && m_tf) found = 1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL tf_tick_align: got none expected a tick cycle");
    end
    cs = 1'b1; rw = 1'b0; addr = 2'd1; di = 8'h01;
    @(negedge clk_in);
    rw = 1'b1; #1;
    n_chk++;
    if ({rdata, irq} !== {8'h01, 1'b1}) begin
      n_fail++;
      $display("FAIL tf_set_wins: got %h/%b expected 01/1", rdata, irq);
    end
    @(negedge clk_in); #1;
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL tf_set_wins_irq: got %b expected 1", irq);
    end
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk_in);
      if (m_ce && !m_tick && m_tf) found = 1;
    end
    cs = 1'b1; rw = 1'b0; addr = 2'd1; di = 8'($urandom) | 8'h01;
    @(negedge clk_in);
    rw = 1'b1; #1;
    n_chk++;
    if ({rdata, irq} !== {8'h00, m_irq}) begin
      n_fail++;
      $display("FAIL tf_clear: got %h/%b expected 00/%b", rdata, irq, m_irq);
    end
    @(negedge clk_in); #1;
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL tf_clear_irq: got %b expected 0", irq);
    end
    cs = 1'b0;
  endtask

  task automatic test_wrap_stop();
    bit         found = 0;
    logic [7:0] exp_t;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk_in);
      if (m_ce && m_tick) found = 1;
    end
    cs = 1'b1; rw = 1'b0; addr = 2'd2; di = 8'hFF;
    @(negedge clk_in);
    rw = 1'b1; #1;
    n_chk++;
    if (rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_write_wins: got %h expected ff", rdata);
    end
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk_in);
      if (m_tick) found = 1;
    end
    @(negedge clk_in); #1;
    n_chk++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_ticks: got %h expected 00", rdata);
    end
    cpu_wr(2'd0, 8'h01);
    exp_t = m_ticks;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      cs = 1'b1; rw = 1'b1; addr = 2'd2; #1;
      n_chk++;
      if (rdata !== exp_t) begin
        n_fail++;
        $display("FAIL stop_ticks cyc%0d: got %h expected %h", i, rdata, exp_t);
      end
    end
    cpu_wr(2'd0, 8'h03);
    for (int i = 1; i <= RTC_DIV; i++) begin
      @(negedge clk_in);
      cs = 1'b1; rw = 1'b1; addr = 2'd2; #1;
      n_chk++;
      if (rdata !== ((i == RTC_DIV) ? exp_t + 8'd1 : exp_t)) begin
        n_fail++;
        $display("FAIL restart_ticks cyc%0d: got %h expected %h", i, rdata,
                 (i == RTC_DIV) ? exp_t + 8'd1 : exp_t);
      end
    end
    cs = 1'b0;
  endtask

  task automatic test_async_reset();
    int ces = 0;
    repeat (30) @(negedge clk_in);
    #2 b_reset = 1'b0;
    #1;
    n_chk++;
    if ({sys_clk, cpu_ce, sys_res, irq} !== 4'b0010) begin
      n_fail++;
      $display("FAIL async_outs: got %b expected 0010", {sys_clk, cpu_ce, sys_res, irq});
    end
    cs = 1'b1; rw = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      n_chk++;
      if (rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL async_reg%0d: got %h expected 00", a, rdata);
      end
    end
    @(negedge clk_in);
    #2 b_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in); #1;
      if (m_ce) ces++;
      n_chk++;
      if ({sys_clk, cpu_ce, sys_res, irq} !== {m_sclk, m_ce, m_sres, m_irq}) begin
        n_fail++;
        $display("FAIL async_seq cyc%0d: got %b expected %b", i, {sys_clk, cpu_ce, sys_res, irq},
                 {m_sclk, m_ce, m_sres, m_irq});
      end
      if (m_ce && ces == RES_DELAY - 1) begin
        n_chk++;
        if (sys_res !== 1'b1) begin
          n_fail++;
          $display("FAIL async_hold: got %b expected 1", sys_res);
        end
      end
    end
    cs = 1'b0;
  endtask

  task automatic test_random();
    cpu_wr(2'd0, 8'h03);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 3) == 0) begin
        cs = 1'b1; rw = 1'b0; addr = 2'($urandom); di = 8'($urandom);
        if (addr == 2'd0) di[1] = ($urandom_range(0, 3) != 0);
      end else begin
        cs = ($urandom_range(0, 4) != 0); rw = 1'b1; addr = 2'($urandom);
      end
      #1;
      n_chk++;
      if ({sys_clk, cpu_ce, sys_res, irq, rdata} !== {m_sclk, m_ce, m_sres, m_irq, exp_rd(cs, rw, addr)}) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %b/%h expected %b/%h", i, {sys_clk, cpu_ce, sys_res, irq},
                 rdata, {m_sclk, m_ce, m_sres, m_irq}, exp_rd(cs, rw, addr));
      end
    end
    cs = 1'b0; rw = 1'b1;
  endtask

  initial begin
    test_reset();
    test_reset_seq();
    test_rtc_run();
    test_tf_clear();
    test_wrap_stop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_timectl.md
SYS_TIMECTL -- requirements
Module: sys_timectl

Interface
REQ-001 Parameter OSC_CLOCK, default 12000000, input oscillator frequency in Hz.
REQ-002 Parameter CPU_CLOCK, default 3000000, CPU clock frequency in Hz.
REQ-003 Parameter RTC_CLOCK, default 50, RTC tick rate in Hz and ticks per second.
REQ-004 Parameter RES_DELAY, default 4, CPU clock periods of reset hold after b_reset release.
REQ-005 Derived constants: CLK_DIV = OSC_CLOCK/CPU_CLOCK/2, which SHALL be >= 1; RTC_DIV = OSC_CLOCK/RTC_CLOCK, which SHALL be >= 2.
REQ-006 clk_in  in  1  sole clock; all state changes on its rising edge.
REQ-007 b_reset  in  1  asynchronous, active-low reset.
REQ-008 sys_clk  out  1  divided CPU clock, 50% duty.
REQ-009 cpu_ce  out  1  one clk_in cycle pulse, coincident with the sys_clk 0->1 transition.
REQ-010 sys_res  out  1  active-high CPU reset.
REQ-011 cs  in  1  register select, sampled only when cpu_ce=1.
REQ-012 rw  in  1  1 = read, 0 = write.
REQ-013 addr  in  2  register index.
REQ-014 di  in  8  write data.
REQ-015 do  out  8  read data.
REQ-016 irq  out  1  RTC interrupt request, active high.

Function
REQ-017 A divider counter SHALL count clk_in cycles 0..CLK_DIV-1; on reaching CLK_DIV-1 it SHALL wrap to 0 and toggle sys_clk, giving a sys_clk period of 2*CLK_DIV clk_in cycles.
REQ-018 cpu_ce SHALL be registered, high exactly in the clk_in cycle in which sys_clk is 1 following a 0->1 toggle, and low otherwise.
REQ-019 A reset sequencer SHALL hold sys_res=1 until RES_DELAY cpu_ce pulses have elapsed after b_reset release; sys_res SHALL then fall to 0 and remain 0 until the next b_reset assertion.
REQ-020 Registers: 0 CTRL (bit0 IE, bit1 RUN; other bits read 0); 1 STAT (bit0 TF; other bits read 0); 2 TICKS (8-bit); 3 SECS (8-bit).
REQ-021 Writes SHALL occur only in a cycle with cpu_ce=1, cs=1, rw=0 and sys_res=0; CTRL SHALL take di[1:0]; writing STAT with di[0]=1 SHALL clear TF; writing TICKS or SECS SHALL load di.
REQ-022 do SHALL combinationally show the addressed register when cs=1 and rw=1, and 8'hFF otherwise.
REQ-023 While RUN=1, an RTC prescaler SHALL count clk_in cycles 0..RTC_DIV-1 and emit an internal one-cycle tick on the wrap.
REQ-024 While RUN=0, the RTC prescaler and the sub-second counter SHALL be held at 0 and no ticks SHALL occur.
REQ-025 Each tick SHALL set TF, increment TICKS modulo 256, and advance the sub-second counter 0..RTC_CLOCK-1.
REQ-026 On the sub-second wrap, SECS SHALL increment modulo 256.
REQ-027 A tick and a TF clear in the same cycle SHALL leave TF=1 (set wins).
REQ-028 A tick and a CPU write to TICKS or SECS in the same cycle SHALL leave the written value (write wins); the sub-second counter SHALL still advance.
REQ-029 irq SHALL be a registered version of TF AND IE and SHALL update on every clk_in edge.

Reset
REQ-030 While b_reset=0 the block SHALL force sys_clk=0, cpu_ce=0, sys_res=1, irq=0, IE=0, RUN=0, TF=0, TICKS=0, SECS=0, and clear all counters, immediately and without waiting for a clock edge.
REQ-031 A b_reset assertion mid-operation SHALL abort any sequence in progress, and the full RES_DELAY sequence SHALL restart on release.

Verification (sim parameters OSC_CLOCK=48, CPU_CLOCK=12, RTC_CLOCK=4, RES_DELAY=4, giving CLK_DIV=2 and RTC_DIV=12)
REQ-032 Release b_reset -> sys_clk period 4 clk_in cycles; cpu_ce high 1 of every 4 cycles; sys_res falls in the cycle of the 4th cpu_ce.
REQ-033 Write CTRL=8'h03 -> tick every 12 cycles; irq rises 1 cycle after TF; after 4 ticks TICKS=8'h04, SECS=8'h01.
REQ-034 Clear TF in the same cycle as a tick -> TF stays 1 and irq stays 1; clear TF between ticks -> TF=0 and irq=0 on the next edge.
REQ-035 Preload TICKS=8'hFF and let one tick occur -> TICKS=8'h00; write CTRL=8'h01 (RUN=0) -> no further ticks, and the prescaler restarts from 0 when RUN is set again.
REQ-036 Assert b_reset mid-run for 1 cycle -> all outputs reach their reset values asynchronously; the full 4-cpu_ce reset hold is repeated after release.
REQ-037 Read with cs=0, and attempt a write while sys_res=1 -> do=8'hFF; the attempted write has no effect.
